// File: rtl/fp_op_server_pkg.sv
// Shared types and helpers for the FloPoCo shared-operator server.
// Index width is capped by TagIdxW; N_CLIENTS must not exceed 2**TagIdxW.
package fp_op_server_pkg;

  // Fixed tag index width so the tag struct can live in the package.
  localparam int unsigned TagIdxW = 8;

  typedef enum logic [1:0] {
    ExcZero   = 2'b00,
    ExcNormal = 2'b01,
    ExcInf    = 2'b10,
    ExcNan    = 2'b11
  } fp_exc_e;

  typedef struct packed {
    logic               valid;
    logic [TagIdxW-1:0] idx;
  } tag_t;

  function automatic int unsigned fp_width(input int unsigned w_e, input int unsigned w_f);
    return w_e + w_f + 3;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_op_server_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and next pointer.
// The pointer register is owned by the instantiating module.
module rr_arbiter
  import fp_op_server_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_valid_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic [IdxW-1:0] ptr_next_o
);

  logic [IdxW-1:0] cand;

  // Scan from the pointer upward, wrapping at N-1; first requester wins.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o  = 1'b1;
        gnt_idx_o    = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next_o = ptr_i;
    if (gnt_valid_o) begin
      if (32'(gnt_idx_o) == N - 1) begin
        ptr_next_o = '0;
      end else begin
        ptr_next_o = gnt_idx_o + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_op_server.sv
// Issue/return side of one fixed-latency pipelined FloPoCo operator shared by N clients.
// Optional statistics counters: define FP_OP_SERVER_STATS_EN.
module fp_op_server
  import fp_op_server_pkg::*;
#(
  parameter int unsigned W_E       = 8,
  parameter int unsigned W_F       = 23,
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned LAT       = 2,
  localparam int unsigned W        = fp_width(W_E, W_F),
  localparam int unsigned IdxW     = idx_width(N_CLIENTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
`ifdef FP_OP_SERVER_STATS_EN
  output logic [31:0]                     stat_grants_o,
  output logic [31:0]                     stat_stall_o,
`endif
  input  logic [N_CLIENTS-1:0]            req_valid_i,
  input  logic [N_CLIENTS-1:0][W-1:0]     req_x_i,
  input  logic [N_CLIENTS-1:0][W-1:0]     req_y_i,
  output logic [N_CLIENTS-1:0]            req_ready_o,
  output logic [W-1:0]                    op_x_o,
  output logic [W-1:0]                    op_y_o,
  input  logic [W-1:0]                    op_r_i,
  output logic [N_CLIENTS-1:0]            resp_valid_o,
  output logic [W-1:0]                    resp_r_o
);

  logic [N_CLIENTS-1:0] gnt;
  logic                 gnt_valid;
  logic [IdxW-1:0]      gnt_idx;
  logic [IdxW-1:0]      ptr_q, ptr_d;

  logic [W-1:0]         op_x_q, op_x_d;
  logic [W-1:0]         op_y_q, op_y_d;
  logic [W-1:0]         resp_r_q, resp_r_d;
  logic [N_CLIENTS-1:0] resp_valid_q, resp_valid_d;

  tag_t                 tag_d;
  tag_t                 tag_q [LAT+1];

  // With N_CLIENTS == 1 the arbiter always returns pointer 0, so ptr_q stays 0.
  rr_arbiter #(
    .N    (N_CLIENTS),
    .IdxW (IdxW)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .ptr_next_o  (ptr_d)
  );

  assign req_ready_o = gnt;

  // Idle cycles feed zeros so the operator never sees stale operands.
  always_comb begin
    op_x_d = '0;
    op_y_d = '0;
    if (gnt_valid) begin
      op_x_d = req_x_i[gnt_idx];
      op_y_d = req_y_i[gnt_idx];
    end
  end

  always_comb begin
    tag_d.valid = gnt_valid;
    tag_d.idx   = TagIdxW'(gnt_idx);
  end

  always_comb begin
    resp_valid_d = '0;
    resp_r_d     = resp_r_q;
    if (tag_q[LAT].valid) begin
      resp_r_d = op_r_i;
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
        if (tag_q[LAT].idx == TagIdxW'(i)) begin
          resp_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      resp_r_q     <= '0;
      resp_valid_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      resp_r_q     <= resp_r_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Tag stage k travels alongside operator pipeline stage k; the last one aligns with op_r.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s <= LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int unsigned s = 1; s <= LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign op_x_o       = op_x_q;
  assign op_y_o       = op_y_q;
  assign resp_r_o     = resp_r_q;
  assign resp_valid_o = resp_valid_q;

`ifdef FP_OP_SERVER_STATS_EN
  logic [31:0] stat_grants_q;
  logic [31:0] stat_stall_q;
  logic        stall;

  // A cycle stalls when some requester is left without a grant.
  assign stall = |(req_valid_i & ~gnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (gnt_valid && (stat_grants_q != '1)) begin
        stat_grants_q <= stat_grants_q + 32'd1;
      end
      if (stall && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_grants_o = stat_grants_q;
  assign stat_stall_o  = stat_stall_q;
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_fp_op_server.sv
// Self-checking bench for fp_op_server with a behavioural FloPoCo multiplier on op_r.
// Define FP_OP_SERVER_STATS_EN to also check the statistics counters.
module tb_fp_op_server;
  import fp_op_server_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 34;
  localparam int unsigned LAT = 2;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0][W-1:0] req_x;
  logic [N-1:0][W-1:0] req_y;
  logic [N-1:0]       req_ready;
  logic [W-1:0]       op_x, op_y, op_r;
  logic [N-1:0]       resp_valid;
  logic [W-1:0]       resp_r;
`ifdef FP_OP_SERVER_STATS_EN
  logic [31:0]        stat_grants, stat_stall;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  fp_op_server #(
    .W_E       (8),
    .W_F       (23),
    .N_CLIENTS (N),
    .LAT       (LAT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
`ifdef FP_OP_SERVER_STATS_EN
    .stat_grants_o (stat_grants),
    .stat_stall_o  (stat_stall),
`endif
    .req_valid_i   (req_valid),
    .req_x_i       (req_x),
    .req_y_i       (req_y),
    .req_ready_o   (req_ready),
    .op_x_o        (op_x),
    .op_y_o        (op_y),
    .op_r_i        (op_r),
    .resp_valid_o  (resp_valid),
    .resp_r_o      (resp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Truncating FloPoCo single-precision multiply (W_E=8, W_F=23).
  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [1:0]  ea, eb;
    logic        s;
    int          e;
    logic [47:0] m;
    logic [22:0] frac;
    ea = a[33:32];
    eb = b[33:32];
    s  = a[31] ^ b[31];
    if (ea == ExcNan || eb == ExcNan || (ea == ExcZero && eb == ExcInf) ||
        (ea == ExcInf && eb == ExcZero)) return {ExcNan, 32'h0};
    if (ea == ExcInf || eb == ExcInf) return {ExcInf, s, 31'h0};
    if (ea == ExcZero || eb == ExcZero) return {ExcZero, s, 31'h0};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    if (m[47]) begin
      e++;
      frac = m[46:24];
    end else begin
      frac = m[45:23];
    end
    if (e > 255) return {ExcInf, s, 31'h0};
    if (e < 1) return {ExcZero, s, 31'h0};
    return {ExcNormal, s, 8'(e), frac};
  endfunction

  function automatic logic [W-1:0] rand_fp();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return {ExcZero, 1'($urandom_range(0, 1)), 31'h0};
    if (sel == 1) return {ExcInf, 1'($urandom_range(0, 1)), 31'h0};
    if (sel == 2) return {ExcNan, 32'h0};
    return {ExcNormal, 1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Behavioural operator: LAT register stages fed by op_x/op_y.
  logic [W-1:0] op_pipe [LAT];
  always @(posedge clk) begin
    op_pipe[0] <= fp_mul(op_x, op_y);
    for (int s = 1; s < LAT; s++) op_pipe[s] <= op_pipe[s-1];
  end
  assign op_r = op_pipe[LAT-1];

  // Reference model: expected responses scheduled by due cycle.
  typedef struct {
    int unsigned  due;
    logic [1:0]   idx;
    logic [W-1:0] r;
  } exp_t;

  exp_t         sb [$];
  logic [1:0]   p_m;
  logic [W-1:0] opx_m, opy_m, last_r_m;
  int unsigned  grants_m, stalls_m;
  int unsigned  strobes [N];

  always @(negedge clk) begin
    logic [N-1:0] eg, erv;
    logic [1:0]   gi, c;
    logic         found;
    exp_t         e;
    if (!rst_n) begin
      check_eq("rst_resp_valid", resp_valid, '0);
      check_eq("rst_op_x", op_x, '0);
      check_eq("rst_resp_r", resp_r, '0);
      sb.delete();
      p_m      = '0;
      opx_m    = '0;
      opy_m    = '0;
      last_r_m = '0;
      grants_m = 0;
      stalls_m = 0;
    end else begin
`ifdef FP_OP_SERVER_STATS_EN
      check_eq("stat_grants", stat_grants, grants_m);
      check_eq("stat_stall", stat_stall, stalls_m);
`endif
      eg    = '0;
      gi    = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = 2'(int'(p_m) + k);
        if (!found && req_valid[c]) begin
          found = 1'b1;
          gi    = c;
        end
      end
      if (found) eg[gi] = 1'b1;
      check_eq("grant", req_ready, eg);
      check_eq("op_x", op_x, opx_m);
      check_eq("op_y", op_y, opy_m);
      erv = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        erv[sb[0].idx] = 1'b1;
        last_r_m       = sb[0].r;
        void'(sb.pop_front());
      end
      check_eq("resp_valid", resp_valid, erv);
      check_eq("resp_r", resp_r, last_r_m);
      for (int k = 0; k < N; k++) if (resp_valid[k]) strobes[k]++;
      if (found) begin
        e.due = cyc + LAT + 2;
        e.idx = gi;
        e.r   = fp_mul(req_x[gi], req_y[gi]);
        sb.push_back(e);
        opx_m = req_x[gi];
        opy_m = req_y[gi];
        p_m   = gi + 2'd1;
        grants_m++;
      end else begin
        opx_m = '0;
        opy_m = '0;
      end
      if ((req_valid & ~eg) != '0) stalls_m++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]  exp_g;
    int unsigned   snap [N];
    logic [31:0]   g0, s0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    g0 = '0;
    s0 = '0;
    for (int k = 0; k < N; k++) strobes[k] = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset: no strobes, zero operands.
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      check_eq("idle_resp_valid", resp_valid, '0);
      check_eq("idle_op_x", op_x, '0);
    end

    // Single request from client 2: 2.0 * 1.5 = 3.0 after LAT+2 cycles.
    tick();
    req_valid = 4'b0100;
    req_x[2]  = 34'h1_4000_0000;
    req_y[2]  = 34'h1_3FC0_0000;
    @(negedge clk);
    check_eq("c2_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check_eq("c2_op_x", op_x, 34'h1_4000_0000);
    check_eq("c2_op_y", op_y, 34'h1_3FC0_0000);
    repeat (3) tick();
    @(negedge clk);
    check_eq("c2_resp_valid", resp_valid, 4'b0100);
    check_eq("c2_resp_r", resp_r, 34'h1_4040_0000);

    // All four clients for 8 cycles from pointer 0.
    do_reset();
    tick();
    for (int k = 0; k < N; k++) begin
      req_x[k] = rand_fp();
      req_y[k] = rand_fp();
      snap[k]  = strobes[k];
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      exp_g = '0;
      exp_g[k % N] = 1'b1;
      check_eq("rr_order", req_ready, exp_g);
`ifdef FP_OP_SERVER_STATS_EN
      if (k == 0) begin
        g0 = stat_grants;
        s0 = stat_stall;
      end
`endif
    end
    tick();
    req_valid = '0;
    @(negedge clk);
`ifdef FP_OP_SERVER_STATS_EN
    check_eq("stat_grants_delta", stat_grants - g0, 32'd8);
    check_eq("stat_stall_delta", stat_stall - s0, 32'd8);
`endif
    repeat (6) tick();
    for (int k = 0; k < N; k++) check_eq("rr_strobes", strobes[k] - snap[k], 2);

    // Client 3 alone, continuous: grant every cycle, strobe continuous from cycle 4.
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      req_x[3] = 34'h1_3F80_0000;
      req_y[3] = rand_fp();
      @(negedge clk);
      check_eq("c3_ready", req_ready, 4'b1000);
      if (k >= 4) check_eq("c3_resp_valid", resp_valid, 4'b1000);
    end
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Reset one cycle after three back-to-back accepts.
    for (int k = 0; k < 3; k++) begin
      tick();
      req_valid = 4'b0010;
      req_x[1]  = {ExcNormal, 1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
      req_y[1]  = {ExcNormal, 1'b1, 8'($urandom_range(100, 154)), 23'($urandom)};
    end
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check_eq("mid_rst_op_x", op_x, '0);
    check_eq("mid_rst_op_y", op_y, '0);
    check_eq("mid_rst_resp_valid", resp_valid, '0);
    check_eq("mid_rst_resp_r", resp_r, '0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check_eq("post_rst_resp_valid", resp_valid, '0);
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      tick();
      req_valid = 4'($urandom_range(0, 15));
      for (int j = 0; j < N; j++) begin
        req_x[j] = rand_fp();
        req_y[j] = rand_fp();
      end
    end
    tick();
    req_valid = '0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_op_server.md
# fp_op_server

Shared-operator responder for the FloPoCo datapath: owns the issue side of one fixed-latency pipelined FloPoCo operator (fmul or fadd) and serves up to N_CLIENTS MAC-style initiators that present operand pairs. It performs round-robin arbitration and drives the operator's x/y inputs, zeroing them when idle. It tracks each in-flight operation through the operator pipeline with a tag and routes the operator's r output back to the issuing client with a one-hot response strobe.

## Interface
Parameters:
- W_E, 8, FloPoCo exponent width.
- W_F, 23, FloPoCo fraction width; word width W = W_E+W_F+3.
- N_CLIENTS, 4, number of initiators, ≥1.
- LAT, 2, operator pipeline latency in cycles, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_CLIENTS  per-client operand pair present.
- req_x  in  N_CLIENTS×W  per-client x operand.
- req_y  in  N_CLIENTS×W  per-client y operand.
- req_ready  out  N_CLIENTS  one-hot grant, combinational from req_valid and the RR pointer.
- op_x  out  W  registered operand to operator.
- op_y  out  W  registered operand to operator.
- op_r  in  W  operator result.
- resp_valid  out  N_CLIENTS  registered one-hot result strobe.
- resp_r  out  W  registered result, shared by all clients.

## Operation
- Transfer occurs when req_valid[i] and req_ready[i] are both high. At most one transfer per cycle.
- Arbiter: round-robin. Search starts at pointer p and wraps N_CLIENTS-1→0. After a grant to i, p ← (i+1) mod N_CLIENTS. With no grant, p holds.
- On a transfer, op_x/op_y ← req_x[i]/req_y[i] at the next edge. On a cycle with no transfer, they ← 0 at the next edge.
- Tag pipe: LAT+1 stages of {valid, client index}. Stage 0 is loaded alongside op_x/op_y; all stages shift every cycle. No stall, no backpressure.
- When the last tag stage is valid: resp_r ← op_r and resp_valid ← onehot(index) at the next edge. Otherwise resp_valid ← 0 and resp_r holds its last value.
- Clients must accept responses unconditionally. Fixed latency guarantees in-order delivery per client and globally.
- Reset (async assert): op_x, op_y, resp_r ← 0; resp_valid ← 0; all tag stages invalid; p ← 0. req_ready is then driven combinationally from req_valid with p=0.
- Reset mid-operation drops every in-flight operation. No resp_valid is asserted for any request accepted before reset.
- N_CLIENTS=1: req_ready = req_valid; the pointer is a constant 0.

## Timing
- Request accepted in cycle t. op_x/op_y are visible in t+1. op_r is sampled in t+1+LAT. resp_valid/resp_r are visible in t+2+LAT. Total latency is LAT+2.
- Sustained throughput is one operation per cycle. Under all-clients-requesting, each client is granted exactly once every N_CLIENTS cycles.
- A grant and a response for the same client in the same cycle are independent and both take effect.

## Configuration
- FP_OP_SERVER_STATS_EN defined:
  - adds outputs stat_grants (32 bits), which counts transfers;
  - adds outputs stat_stall (32 bits), which counts cycles where any req_valid bit is high without a grant to it;
  - both counters saturate at all-ones and reset to 0.
- Not defined: these ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package fp_op_server_pkg holds:
  - a width function W(W_E,W_F);
  - the client index width ($clog2 with a minimum of 1);
  - a tag struct {valid, idx};
  - FloPoCo exception codes (00 zero, 01 normal, 10 inf, 11 NaN).
- Sub-module rr_arbiter (parameter N): req vector plus pointer in, one-hot grant plus next-pointer out, purely combinational. The pointer register lives in fp_op_server.

## Test plan
Defaults (W=34), with a behavioural FloPoCo multiplier of latency LAT=2 on op_r:
- Reset held, then released, with no requests → op_x=op_y=0, resp_valid=0, and no strobes for 20 cycles.
- Client 2 sends x=34'h1_4000_0000 (2.0), y=34'h1_3FC0_0000 (1.5) in cycle t → req_ready=4'b0100 in t. op_x/op_y carry the operands in t+1. resp_valid=4'b0100 and resp_r=34'h1_4040_0000 (3.0) in t+4.
- All four clients valid for 8 cycles from p=0 → grant order 0,1,2,3,0,1,2,3. Each client receives exactly two strobes, in the same order, 4 cycles after its grant.
- Client 3 alone, valid every cycle with x=1.0 (34'h1_3F80_0000) → grant every cycle, pointer wraps 3→0→3, and resp_valid[3] is high continuously from cycle 4.
- rst_n asserted for 1 cycle, 1 cycle after three back-to-back accepts → outputs are immediately 0 and no resp_valid is asserted for those requests.
- With FP_OP_SERVER_STATS_EN, run the 4-client scenario → stat_grants=8 and stat_stall=8.
